// File: rtl/decoder_scan_n.sv
// Registered N-to-2^N one-hot decoder with hold, single-cycle pulse and auto-scan modes.
// The one-hot vector is kept in a register; y is only a polarity inversion of it.
module decoder_scan_n #(
    parameter  int SEL_W      = 4,
    parameter  int DWELL_W    = 8,
    parameter  bit ACTIVE_LOW = 1'b0,
    localparam int OUT_N      = 2**SEL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic               load,
    input  logic [SEL_W-1:0]   sel,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_N-1:0]   y,
    output logic [SEL_W-1:0]   idx,
    output logic               valid,
    output logic               wrap
);
    localparam logic [1:0] M_HOLD  = 2'b00;
    localparam logic [1:0] M_PULSE = 2'b01;
    localparam logic [1:0] M_SCAN  = 2'b10;
    localparam logic [1:0] M_OFF   = 2'b11;

    logic [OUT_N-1:0]   oh, oh_d;
    logic [SEL_W-1:0]   idx_d;
    logic               valid_d, wrap_d;
    logic [DWELL_W-1:0] cnt, cnt_d;
    logic [1:0]         mode_q, mode_d;

    function automatic logic [OUT_N-1:0] dec(input logic [SEL_W-1:0] s);
        dec    = '0;
        dec[s] = 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            oh     <= '0;
            idx    <= '0;
            valid  <= 1'b0;
            wrap   <= 1'b0;
            cnt    <= '0;
            mode_q <= M_OFF;
        end else begin
            oh     <= oh_d;
            idx    <= idx_d;
            valid  <= valid_d;
            wrap   <= wrap_d;
            cnt    <= cnt_d;
            mode_q <= mode_d;
        end
    end

    always_comb begin
        oh_d    = oh;
        idx_d   = idx;
        valid_d = valid;
        wrap_d  = 1'b0;
        cnt_d   = cnt;
        mode_d  = mode_q;
        if (!en) begin
            // a pulse must never stretch, even while the clock enable is low
            if (mode_q == M_PULSE) begin
                oh_d    = '0;
                valid_d = 1'b0;
            end
        end else begin
            mode_d = mode;
            case (mode)
                M_HOLD: begin
                    cnt_d = '0;
                    if (load) begin
                        oh_d    = dec(sel);
                        idx_d   = sel;
                        valid_d = 1'b1;
                    end
                end
                M_PULSE: begin
                    cnt_d = '0;
                    if (load) begin
                        oh_d    = dec(sel);
                        idx_d   = sel;
                        valid_d = 1'b1;
                    end else begin
                        oh_d    = '0;
                        valid_d = 1'b0;
                    end
                end
                M_SCAN: begin
                    valid_d = 1'b1;
                    if (load || mode != mode_q) begin
                        idx_d = load ? sel : '0;
                        cnt_d = '0;
                    end else if (cnt >= dwell) begin
                        // live dwell compare: shrinking it mid-count advances at once
                        idx_d  = idx + 1'b1;
                        cnt_d  = '0;
                        wrap_d = (idx == {SEL_W{1'b1}});
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                    oh_d = dec(idx_d);
                end
                default: begin
                    oh_d    = '0;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign y = ACTIVE_LOW ? ~oh : oh;

endmodule
